// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush controller: load-use and branch hazards, multi-cycle divide sequencing, exception flush.
// Optional divide sequencing is compiled in when PIPE_DIV_EN is defined.
module pipeline_ctrl #(
   parameter int RA_W = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [RA_W-1:0] id_rs,
   input  logic [RA_W-1:0] id_rt,
   input  logic            id_use_rt,
   input  logic            id_branch,
   input  logic            ex_memread,
   input  logic            ex_regwrite,
   input  logic [RA_W-1:0] ex_wreg,
   input  logic            mem_memread,
   input  logic [RA_W-1:0] mem_wreg,
   input  logic            ex_div,
   input  logic            div_ready,
   input  logic            mem_excp,
   output logic            en_pc,
   output logic            en_fd,
   output logic            en_de,
   output logic            en_em,
   output logic            en_mw,
   output logic            clr_fd,
   output logic            clr_de,
   output logic            clr_em,
   output logic            clr_mw,
   output logic            div_start,
   output logic            div_cancel,
   output logic            excp_redirect
);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      DIV_BUSY = 2'd1,
      FLUSH    = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic load_use;
   logic branch_haz;
   logic hazard;

   // A producer matches when it writes a non-zero register that ID actually reads.
   function automatic logic src_match(input logic [RA_W-1:0] wreg,
                                      input logic [RA_W-1:0] rs,
                                      input logic [RA_W-1:0] rt,
                                      input logic            use_rt);
      return (wreg != '0) && ((wreg == rs) || (use_rt && (wreg == rt)));
   endfunction

   assign load_use   = ex_memread && src_match(ex_wreg, id_rs, id_rt, id_use_rt);
   assign branch_haz = id_branch &&
                       ((ex_regwrite && src_match(ex_wreg,  id_rs, id_rt, id_use_rt)) ||
                        (mem_memread && src_match(mem_wreg, id_rs, id_rt, id_use_rt)));
   assign hazard     = load_use || branch_haz;

`ifndef PIPE_DIV_EN
   logic unused_div;
   assign unused_div = ex_div ^ div_ready;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= RUN;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      en_pc         = 1'b1;
      en_fd         = 1'b1;
      en_de         = 1'b1;
      en_em         = 1'b1;
      en_mw         = 1'b1;
      clr_fd        = 1'b0;
      clr_de        = 1'b0;
      clr_em        = 1'b0;
      clr_mw        = 1'b0;
      div_start     = 1'b0;
      div_cancel    = 1'b0;
      excp_redirect = 1'b0;

      if (rst) begin
         clr_fd    = 1'b1;
         clr_de    = 1'b1;
         clr_em    = 1'b1;
         clr_mw    = 1'b1;
         state_nxt = RUN;
      end else begin
         case (state)
            RUN: begin
               if (mem_excp) begin
                  clr_fd        = 1'b1;
                  clr_de        = 1'b1;
                  clr_em        = 1'b1;
                  clr_mw        = 1'b1;
                  excp_redirect = 1'b1;
                  state_nxt     = FLUSH;
`ifdef PIPE_DIV_EN
               end else if (ex_div) begin
                  // Freeze PC..EX/MEM around the divide and bubble WB.
                  div_start = 1'b1;
                  en_pc     = 1'b0;
                  en_fd     = 1'b0;
                  en_de     = 1'b0;
                  en_em     = 1'b0;
                  clr_mw    = 1'b1;
                  state_nxt = DIV_BUSY;
`endif
               end else if (hazard) begin
                  en_pc  = 1'b0;
                  en_fd  = 1'b0;
                  clr_de = 1'b1;
               end
            end

            DIV_BUSY: begin
`ifdef PIPE_DIV_EN
               if (mem_excp) begin
                  clr_fd        = 1'b1;
                  clr_de        = 1'b1;
                  clr_em        = 1'b1;
                  clr_mw        = 1'b1;
                  excp_redirect = 1'b1;
                  div_cancel    = 1'b1;
                  state_nxt     = FLUSH;
               end else if (!div_ready) begin
                  en_pc  = 1'b0;
                  en_fd  = 1'b0;
                  en_de  = 1'b0;
                  en_em  = 1'b0;
                  clr_mw = 1'b1;
               end else begin
                  // Result lands this edge; the divide leaves EX with the release.
                  state_nxt = RUN;
               end
`else
               state_nxt = RUN;
`endif
            end

            FLUSH: begin
               // Kill the instruction fetched from the old path; everything else already cleared.
               clr_fd    = 1'b1;
               state_nxt = RUN;
            end

            default: begin
               state_nxt = RUN;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios plus randomized traffic against a behavioural model.
`timescale 1ns/1ps
module tb_pipeline_ctrl;
   localparam int RA_W = 5;
`ifdef PIPE_DIV_EN
   localparam bit DIV_EN = 1'b1;
`else
   localparam bit DIV_EN = 1'b0;
`endif

   // Bit order: en_pc en_fd en_de en_em en_mw | clr_fd clr_de clr_em clr_mw | div_start div_cancel excp_redirect
   localparam logic [11:0] RUNV   = 12'b11111_0000_000;
   localparam logic [11:0] RSTV   = 12'b11111_1111_000;
   localparam logic [11:0] HAZV   = 12'b00111_0100_000;
   localparam logic [11:0] DSTL   = 12'b00001_0001_000;
   localparam logic [11:0] DSTART = 12'b00001_0001_100;
   localparam logic [11:0] EXCV   = 12'b11111_1111_001;
   localparam logic [11:0] EXCD   = 12'b11111_1111_011;
   localparam logic [11:0] FLV    = 12'b11111_1000_000;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [RA_W-1:0] id_rs = '0, id_rt = '0, ex_wreg = '0, mem_wreg = '0;
   logic id_use_rt = 1'b0, id_branch = 1'b0, ex_memread = 1'b0, ex_regwrite = 1'b0;
   logic mem_memread = 1'b0, ex_div = 1'b0, div_ready = 1'b0, mem_excp = 1'b0;
   logic en_pc, en_fd, en_de, en_em, en_mw, clr_fd, clr_de, clr_em, clr_mw;
   logic div_start, div_cancel, excp_redirect;
   logic [11:0] obs;

   int checks = 0;
   int failures = 0;

   // Model state: is a divide outstanding, is the one-cycle post-exception flush pending.
   logic m_busy = 1'b0;
   logic m_flush = 1'b0;

   always #5 clk = ~clk;

   pipeline_ctrl #(.RA_W(RA_W)) dut (
      .clk(clk), .rst(rst),
      .id_rs(id_rs), .id_rt(id_rt), .id_use_rt(id_use_rt), .id_branch(id_branch),
      .ex_memread(ex_memread), .ex_regwrite(ex_regwrite), .ex_wreg(ex_wreg),
      .mem_memread(mem_memread), .mem_wreg(mem_wreg),
      .ex_div(ex_div), .div_ready(div_ready), .mem_excp(mem_excp),
      .en_pc(en_pc), .en_fd(en_fd), .en_de(en_de), .en_em(en_em), .en_mw(en_mw),
      .clr_fd(clr_fd), .clr_de(clr_de), .clr_em(clr_em), .clr_mw(clr_mw),
      .div_start(div_start), .div_cancel(div_cancel), .excp_redirect(excp_redirect)
   );

   assign obs = {en_pc, en_fd, en_de, en_em, en_mw, clr_fd, clr_de, clr_em, clr_mw,
                 div_start, div_cancel, excp_redirect};

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_busy  <= 1'b0;
         m_flush <= 1'b0;
      end else if (m_flush) begin
         m_flush <= 1'b0;
      end else if (mem_excp) begin
         m_flush <= 1'b1;
         m_busy  <= 1'b0;
      end else if (m_busy) begin
         m_busy <= !div_ready;
      end else if (DIV_EN && ex_div) begin
         m_busy <= 1'b1;
      end
   end

   function automatic logic [11:0] ref_out();
      logic [RA_W-1:0] s;
      bit hz;
      if (rst) return RSTV;
      if (m_flush) return FLV;
      if (mem_excp) return m_busy ? EXCD : EXCV;
      if (m_busy) return div_ready ? RUNV : DSTL;
      if (DIV_EN && ex_div) return DSTART;
      hz = 1'b0;
      for (int i = 0; i < 2; i++) begin
         s = (i == 0) ? id_rs : id_rt;
         if ((i == 0 || id_use_rt) && s != 0) begin
            if (ex_memread && ex_wreg == s) hz = 1'b1;
            if (id_branch && ((ex_regwrite && ex_wreg == s) || (mem_memread && mem_wreg == s))) hz = 1'b1;
         end
      end
      return hz ? HAZV : RUNV;
   endfunction

   task automatic idle_inputs();
      id_rs = '0; id_rt = '0; ex_wreg = '0; mem_wreg = '0;
      id_use_rt = 1'b0; id_branch = 1'b0; ex_memread = 1'b0; ex_regwrite = 1'b0;
      mem_memread = 1'b0; ex_div = 1'b0; div_ready = 1'b0; mem_excp = 1'b0;
   endtask

   task automatic test_reset();
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         id_rs = RA_W'($urandom_range(0, 3)); ex_wreg = id_rs; ex_memread = 1'b1;
         mem_excp = $urandom_range(0, 1); ex_div = 1'b1;
         #1;
         checks++;
         if (obs !== RSTV) begin failures++; $display("FAIL reset_hold[%0d] out=%b required=%b", c, obs, RSTV); end
      end
      @(negedge clk);
      rst = 1'b0;
      idle_inputs();
      #1;
      checks++;
      if (obs !== RUNV) begin failures++; $display("FAIL reset_release out=%b required=%b", obs, RUNV); end
   endtask

   task automatic test_load_use();
      logic [11:0] exp;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         idle_inputs();
         case (c)
            0: begin ex_memread = 1'b1; ex_wreg = 5'd5; id_rs = 5'd5; exp = HAZV; end
            1: exp = RUNV;
            2: begin ex_memread = 1'b1; ex_wreg = 5'd0; id_rs = 5'd0; exp = RUNV; end
            3: begin ex_memread = 1'b1; ex_wreg = 5'd9; id_rt = 5'd9; id_use_rt = 1'b0; exp = RUNV; end
            default: begin ex_memread = 1'b1; ex_wreg = 5'd9; id_rt = 5'd9; id_use_rt = 1'b1; exp = HAZV; end
         endcase
         #1;
         checks++;
         if (obs !== exp) begin failures++; $display("FAIL load_use[%0d] out=%b required=%b", c, obs, exp); end
      end
   endtask

   task automatic test_branch();
      logic [11:0] exp;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         idle_inputs();
         id_branch = 1'b1; id_use_rt = 1'b1; id_rt = 5'd7; id_rs = 5'd3;
         case (c)
            0: begin ex_regwrite = 1'b1; ex_wreg = 5'd7; exp = HAZV; end
            1: begin mem_memread = 1'b1; mem_wreg = 5'd7; exp = HAZV; end
            2: exp = RUNV;
            default: begin id_branch = 1'b0; ex_regwrite = 1'b1; ex_wreg = 5'd3; exp = RUNV; end
         endcase
         #1;
         checks++;
         if (obs !== exp) begin failures++; $display("FAIL branch[%0d] out=%b required=%b", c, obs, exp); end
      end
   endtask

   task automatic test_divide();
      logic [11:0] exp;
      int em_low, starts;
      em_low = 0; starts = 0;
      for (int c = 0; c < 13; c++) begin
         @(negedge clk);
         idle_inputs();
         ex_div = (c <= 11);
         div_ready = (c == 11);
         #1;
         if (c == 0) exp = DIV_EN ? DSTART : RUNV;
         else if (c <= 10) exp = DIV_EN ? DSTL : RUNV;
         else exp = RUNV;
         checks++;
         if (obs !== exp) begin failures++; $display("FAIL divide[%0d] out=%b required=%b", c, obs, exp); end
         if (!en_em) em_low++;
         if (div_start) starts++;
      end
      checks++;
      if (em_low != (DIV_EN ? 11 : 0)) begin
         failures++; $display("FAIL divide_stall_len got=%0d required=%0d", em_low, DIV_EN ? 11 : 0);
      end
      checks++;
      if (starts != (DIV_EN ? 1 : 0)) begin
         failures++; $display("FAIL divide_starts got=%0d required=%0d", starts, DIV_EN ? 1 : 0);
      end
   endtask

   task automatic test_excp_in_div();
      logic [11:0] exp;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         idle_inputs();
         ex_div = (c <= 4);
         if (c >= 4) begin ex_memread = 1'b1; ex_wreg = 5'd6; id_rs = 5'd6; end
         mem_excp = (c == 4 || c == 5);
         #1;
         case (c)
            0: exp = DIV_EN ? DSTART : RUNV;
            1, 2, 3: exp = DIV_EN ? DSTL : RUNV;
            4: exp = DIV_EN ? EXCD : EXCV;
            5: exp = FLV;
            default: exp = HAZV;
         endcase
         checks++;
         if (obs !== exp) begin failures++; $display("FAIL excp_in_div[%0d] out=%b required=%b", c, obs, exp); end
      end
   endtask

   task automatic test_reset_mid_div();
      logic [11:0] exp;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         idle_inputs();
         ex_div = (c <= 3);
         rst = (c == 4 || c == 5);
         div_ready = (c == 7);
         #1;
         if (c == 0) exp = DIV_EN ? DSTART : RUNV;
         else if (c <= 3) exp = DIV_EN ? DSTL : RUNV;
         else if (c <= 5) exp = RSTV;
         else exp = RUNV;
         checks++;
         if (obs !== exp) begin failures++; $display("FAIL reset_mid_div[%0d] out=%b required=%b", c, obs, exp); end
      end
   endtask

   task automatic test_random();
      logic [11:0] exp;
      for (int n = 0; n < 1500; n++) begin
         @(negedge clk);
         rst = ($urandom_range(0, 79) == 0);
         id_rs = RA_W'($urandom_range(0, 3));
         id_rt = RA_W'($urandom_range(0, 3));
         ex_wreg = RA_W'($urandom_range(0, 3));
         mem_wreg = RA_W'($urandom_range(0, 3));
         id_use_rt = $urandom_range(0, 1);
         id_branch = ($urandom_range(0, 2) == 0);
         ex_memread = ($urandom_range(0, 2) == 0);
         ex_regwrite = $urandom_range(0, 1);
         mem_memread = ($urandom_range(0, 2) == 0);
         ex_div = ($urandom_range(0, 7) == 0);
         div_ready = m_busy && ($urandom_range(0, 4) == 0);
         mem_excp = ($urandom_range(0, 19) == 0);
         #1;
         exp = ref_out();
         checks++;
         if (obs !== exp) begin failures++; $display("FAIL random[%0d] out=%b required=%b", n, obs, exp); end
      end
      @(negedge clk);
      rst = 1'b0;
      idle_inputs();
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_branch();
      test_divide();
      test_excp_in_div();
      test_reset_mid_div();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
